// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit common-anode seven-segment scan driver with shadowed, tear-free frame updates.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module seven_seg_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  hex_mode,
  output logic [7:0]            Seven_Seg,
  output logic [DIGITS-1:0]     Anode,
  output logic                  frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // Scan counters
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          tick;
  logic          wrap;

  // Shadow (host side) and display (scan side) copies
  logic [4*DIGITS-1:0] shadow_val_reg;
  logic [DIGITS-1:0]   shadow_dp_reg;
  logic [DIGITS-1:0]   shadow_en_reg;
  logic [4*DIGITS-1:0] disp_val_reg;
  logic [DIGITS-1:0]   disp_dp_reg;
  logic [DIGITS-1:0]   disp_en_reg;

  // Output register
  logic [7:0]        seg_reg, seg_next;
  logic [DIGITS-1:0] anode_reg, anode_next;
  logic              frame_done_reg;

  // Per-digit view of the display registers
  logic [3:0]        disp_nib [DIGITS];
  logic [DIGITS-1:0] lzb_mask;

  // Selected digit
  logic [3:0] sel_nib;
  logic       sel_dp;
  logic       sel_en;
  logic       sel_lzb;

  // Active-low g..a pattern; BCD mode blanks codes 10-15.
  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    if (!hex && (nib > 4'h9)) begin
      pat = 7'h7F;
    end
    return pat;
  endfunction

  assign tick = (cnt_reg == CNT_LAST);
  assign wrap = tick && (idx_reg == IDX_LAST);

  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    idx_next = idx_reg;
    if (tick) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
    end
  end

  // Display only follows the shadow at frame wrap, so a frame never mixes old and new data.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_val_reg <= '0;
      shadow_dp_reg  <= '0;
      shadow_en_reg  <= '0;
      disp_val_reg   <= '0;
      disp_dp_reg    <= '0;
      disp_en_reg    <= '0;
    end else begin
      if (load) begin
        shadow_val_reg <= value;
        shadow_dp_reg  <= dp_in;
        shadow_en_reg  <= digit_en;
      end
      if (wrap) begin
        disp_val_reg <= shadow_val_reg;
        disp_dp_reg  <= shadow_dp_reg;
        disp_en_reg  <= shadow_en_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign disp_nib[gi] = disp_val_reg[4*gi +: 4];
    end
  endgenerate

`ifdef SEG_LZB_EN
  // Walk down from the top digit; disabled digits do not stop the run of leading zeros.
  logic lz_run;
  always_comb begin
    lz_run   = 1'b1;
    lzb_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run      = lz_run && (!disp_en_reg[i] || ((disp_nib[i] == 4'h0) && !disp_dp_reg[i]));
      lzb_mask[i] = lz_run;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  always_comb begin
    sel_nib = '0;
    sel_dp  = 1'b0;
    sel_en  = 1'b0;
    sel_lzb = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IW'(i)) begin
        sel_nib = disp_nib[i];
        sel_dp  = disp_dp_reg[i];
        sel_en  = disp_en_reg[i];
        sel_lzb = lzb_mask[i];
      end
    end
  end

  // cnt==0 forces a dark guard cycle so the previous digit cannot ghost onto the new anode.
  always_comb begin
    seg_next   = 8'hFF;
    anode_next = '1;
    if ((cnt_reg != '0) && sel_en) begin
      anode_next = ~(DIGITS'(1) << idx_reg);
      if (!sel_lzb) begin
        seg_next = {~sel_dp, decode(sel_nib, hex_mode)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_reg        <= 8'hFF;
      anode_reg      <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      seg_reg        <= seg_next;
      anode_reg      <= anode_next;
      frame_done_reg <= wrap;
    end
  end

  assign Seven_Seg  = seg_reg;
  assign Anode      = anode_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

- Multiplexed N-digit seven-segment display driver: the parametrised successor to the single-digit combinational decoder.
- Latches a packed nibble vector with per-digit decimal-point and enable bits, and scans one digit at a time at a programmable refresh rate.
- Decodes BCD or full hex, with a one-cycle anti-ghost blank at every digit change.
- Sits between the datapath result registers and the board's common-anode display pins.

## Interface
- `DIGITS`, 8: number of digits scanned (1..16).
- `REFRESH_DIV`, 100000: clock cycles per digit slot (≥2); 100000 at 100 MHz gives 1 kHz per digit.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `load` in 1: one-cycle strobe; captures `value`, `dp_in`, `digit_en` into shadow registers.
- `value` in 4*DIGITS: digit i is `value[4i+3:4i]`; digit 0 is the rightmost.
- `dp_in` in DIGITS: per-digit decimal point, 1 = lit.
- `digit_en` in DIGITS: per-digit enable; 0 = digit fully dark.
- `hex_mode` in 1: 1 = decode 0–F; 0 = BCD, where codes 10–15 display blank.
- `Seven_Seg` out 8: active-low segments; bit 7 = dp, bits 6:0 = g..a.
- `Anode` out DIGITS: active-low digit selects; at most one bit low.
- `frame_done` out 1: one-cycle pulse when the scan wraps to digit 0.

## Operation
- **Shadow registers**
  - On `load`, shadow ← {`value`, `dp_in`, `digit_en`}.
  - Display registers ← shadow only at frame wrap, so a frame never tears.
- **Scan counters**
  - Prescaler `cnt` counts 0..REFRESH_DIV-1.
  - `tick` = (`cnt` == REFRESH_DIV-1).
  - On `tick`: `idx` ← `idx`+1, wrapping DIGITS-1 → 0.
  - On the wrapping tick: display ← shadow, and `frame_done` goes high the next cycle for exactly one cycle.
- **Decode** (active-low segment patterns):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Hex mode adds A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - dp lit clears bit 7.
- **Blanking**
  - A blanked digit drives `Seven_Seg`=FF.
  - A disabled digit (`digit_en`[idx]=0) also keeps `Anode` all ones.
  - A BCD-invalid code blanks the segments, but the decimal point is still honoured.
- **Output register**
  - `Anode`/`Seven_Seg` are registered.
  - Next-state is blank (all ones) when `cnt`==0; otherwise it is the decode of display digit `idx`.
  - Gives a one-cycle dark guard at each slot start.
- **Reset**
  - Internal: `cnt`=0, `idx`=0, shadow and display = 0.
  - Outputs: `Anode`=all ones, `Seven_Seg`=FF, `frame_done`=0.
  - A reset mid-frame aborts the scan; the next frame starts at digit 0 with zeroed (disabled) contents.

## Timing
- After reset release, the first slot is digit 0.
- Output register latency is one cycle: the outputs lag `cnt`/`idx` by one cycle.
  - Digit 0's dark guard is visible in the cycle after the first post-reset edge.
  - It is lit for the following REFRESH_DIV-1 cycles.
- Frame period: DIGITS×REFRESH_DIV cycles. Per-digit lit time: REFRESH_DIV-1 cycles.
- Latency from `load` to display: the new data takes effect at the next wrap tick and is visible from digit 0 of the following frame.
  - Worst case: DIGITS×REFRESH_DIV+2 cycles.
- Simultaneous `load` and wrap tick: display takes the old shadow; the new data appears one frame later.
- Repeated `load` within a frame: the last one wins.
- `hex_mode` is not shadowed; it takes effect on the next output-register update.

## Configuration
- `SEG_LZB_EN` defined (leading-zero blanking):
  - Digit i>0 is blanked when it and every higher enabled digit hold 0 and their dp bits are 0.
  - Digit 0 is never blanked.
  - Blanking is computed on the display registers.
- `SEG_LZB_EN` undefined: all enabled digits show their value, including leading zeros.

## Test plan
- **Reset:** assert `reset` mid-scan.
  - `Anode`=F, `Seven_Seg`=FF, `frame_done`=0 the next cycle.
  - After release, the scan restarts at digit 0 and all digits stay dark (`digit_en`=0).
- **Basic scan** (DIGITS=4, REFRESH_DIV=4, BCD): `load` `value`=16'h1234, `dp_in`=0, `digit_en`=F.
  - Next frame cycles `Anode` E,D,B,7 with `Seven_Seg` 99,B0,A4,F9.
  - Each digit: 1 dark cycle then 3 lit cycles.
  - `frame_done` pulses every 16 cycles.
- **Hex vs BCD and dp:** `value`=16'hAF0C, `dp_in`=4'b0010.
  - `hex_mode`=1: 0x0C→C6, 0x00→40 (C0 with dp lit), 0x0F→8E, 0x0A→88.
  - `hex_mode`=0: codes 10–15 → FF; 0x00 with dp lit → 40.
- **Tear-free update:** pulse `load` with 16'h5678 on the same cycle as the wrap tick.
  - The following frame still shows 1234; 5678 appears the frame after.
- **Disable:** `digit_en`=4'b0101.
  - During slots 1 and 3, `Anode` stays F and `Seven_Seg` stays FF.
- **Leading-zero blanking:** with `SEG_LZB_EN`, `value`=16'h0040.
  - Digits 3 and 2 are dark; digits 1 and 0 show 99 and C0.
  - With dp set on digit 3, that digit shows 40.
  - Without the macro, all four digits are lit.
